// File: rtl/ysyx_22050133_mem_arbiter.sv
// Two-master (icache m0, dcache m1) to one-slave burst arbiter with round-robin tie-breaking.
// The grant is held from the address phase through the final data beat; request fields are never latched.
module ysyx_22050133_mem_arbiter #(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     m0_rw_addr_valid_i,
    output logic                     m0_rw_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] m0_rw_addr_i,
    input  logic                     m0_rw_we_i,
    input  logic [7:0]               m0_rw_len_i,
    input  logic [2:0]               m0_rw_size_i,
    input  logic [1:0]               m0_rw_burst_i,
    input  logic                     m0_rw_if_i,
    input  logic                     m0_w_data_valid_i,
    output logic                     m0_w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] m0_w_data_i,
    output logic                     m0_r_data_valid_o,
    input  logic                     m0_r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] m0_r_data_o,

    input  logic                     m1_rw_addr_valid_i,
    output logic                     m1_rw_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] m1_rw_addr_i,
    input  logic                     m1_rw_we_i,
    input  logic [7:0]               m1_rw_len_i,
    input  logic [2:0]               m1_rw_size_i,
    input  logic [1:0]               m1_rw_burst_i,
    input  logic                     m1_rw_if_i,
    input  logic                     m1_w_data_valid_i,
    output logic                     m1_w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] m1_w_data_i,
    output logic                     m1_r_data_valid_o,
    input  logic                     m1_r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] m1_r_data_o,

    output logic                     s_rw_addr_valid_o,
    input  logic                     s_rw_addr_ready_i,
    output logic [RW_ADDR_WIDTH-1:0] s_rw_addr_o,
    output logic                     s_rw_we_o,
    output logic [7:0]               s_rw_len_o,
    output logic [2:0]               s_rw_size_o,
    output logic [1:0]               s_rw_burst_o,
    output logic                     s_rw_if_o,
    output logic                     s_w_data_valid_o,
    input  logic                     s_w_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] s_w_data_o,
    input  logic                     s_r_data_valid_i,
    output logic                     s_r_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] s_r_data_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q,  last_d;
    logic [7:0]  cnt_q,   cnt_d;

    logic                     sel_addr_valid;
    logic [RW_ADDR_WIDTH-1:0] sel_addr;
    logic                     sel_we;
    logic [7:0]               sel_len;
    logic [2:0]               sel_size;
    logic [1:0]               sel_burst;
    logic                     sel_if;
    logic                     sel_w_valid;
    logic [RW_DATA_WIDTH-1:0] sel_w_data;
    logic                     sel_r_ready;

    logic in_addr, in_wdata, in_rdata;
    logic addr_hs, w_hs, r_hs, beat_hs;

    // Request fields of whichever master currently owns the grant.
    always_comb begin
        if (grant_q) begin
            sel_addr_valid = m1_rw_addr_valid_i;
            sel_addr       = m1_rw_addr_i;
            sel_we         = m1_rw_we_i;
            sel_len        = m1_rw_len_i;
            sel_size       = m1_rw_size_i;
            sel_burst      = m1_rw_burst_i;
            sel_if         = m1_rw_if_i;
            sel_w_valid    = m1_w_data_valid_i;
            sel_w_data     = m1_w_data_i;
            sel_r_ready    = m1_r_data_ready_i;
        end else begin
            sel_addr_valid = m0_rw_addr_valid_i;
            sel_addr       = m0_rw_addr_i;
            sel_we         = m0_rw_we_i;
            sel_len        = m0_rw_len_i;
            sel_size       = m0_rw_size_i;
            sel_burst      = m0_rw_burst_i;
            sel_if         = m0_rw_if_i;
            sel_w_valid    = m0_w_data_valid_i;
            sel_w_data     = m0_w_data_i;
            sel_r_ready    = m0_r_data_ready_i;
        end
    end

    assign in_addr  = (state_q == ADDR);
    assign in_wdata = (state_q == WDATA);
    assign in_rdata = (state_q == RDATA);

    assign addr_hs = in_addr  && sel_addr_valid && s_rw_addr_ready_i;
    assign w_hs    = in_wdata && sel_w_valid    && s_w_data_ready_i;
    assign r_hs    = in_rdata && s_r_data_valid_i && sel_r_ready;
    assign beat_hs = w_hs || r_hs;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0_rw_addr_valid_i || m1_rw_addr_valid_i) begin
                    // On a tie the port that was not served most recently wins.
                    if (m0_rw_addr_valid_i && m1_rw_addr_valid_i) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = m1_rw_addr_valid_i;
                    end
                    last_d  = grant_d;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (addr_hs) begin
                    cnt_d   = sel_len;
                    state_d = sel_we ? WDATA : RDATA;
                end
            end
            WDATA, RDATA: begin
                if (beat_hs) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_rw_addr_valid_o = in_addr && sel_addr_valid;
    assign s_rw_addr_o       = sel_addr;
    assign s_rw_we_o         = sel_we;
    assign s_rw_len_o        = sel_len;
    assign s_rw_size_o       = sel_size;
    assign s_rw_burst_o      = sel_burst;
    assign s_rw_if_o         = sel_if;

    assign s_w_data_valid_o  = in_wdata && sel_w_valid;
    assign s_w_data_o        = sel_w_data;
    assign s_r_data_ready_o  = in_rdata && sel_r_ready;

    assign m0_rw_addr_ready_o = in_addr  && !grant_q && s_rw_addr_ready_i;
    assign m1_rw_addr_ready_o = in_addr  &&  grant_q && s_rw_addr_ready_i;
    assign m0_w_data_ready_o  = in_wdata && !grant_q && s_w_data_ready_i;
    assign m1_w_data_ready_o  = in_wdata &&  grant_q && s_w_data_ready_i;
    assign m0_r_data_valid_o  = in_rdata && !grant_q && s_r_data_valid_i;
    assign m1_r_data_valid_o  = in_rdata &&  grant_q && s_r_data_valid_i;

    // Read data is shared by both masters; only the handshake is steered.
    assign m0_r_data_o = s_r_data_i;
    assign m1_r_data_o = s_r_data_i;

endmodule

// File: tb/tb_ysyx_22050133_mem_arbiter.sv
// Randomized scoreboard bench: masters and slave are driven independently, a monitor checks routing and data.
// Expected grant order comes from a round-robin model of who was served last.
module tb_ysyx_22050133_mem_arbiter;

    localparam int MAXW = 600;

    typedef struct {
        bit          m;
        logic [63:0] addr;
        logic        we;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        ifb;
    } tx_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  m_av, m_we, m_if, m_wv, m_rr;
    logic [63:0] m_addr [2];
    logic [63:0] m_wd   [2];
    logic [7:0]  m_len  [2];
    logic [2:0]  m_size [2];
    logic [1:0]  m_burst[2];
    wire  [1:0]  m_ar, m_wr, m_rv;
    wire  [63:0] m0_rd, m1_rd;

    wire         s_rw_addr_valid_o;
    logic        s_rw_addr_ready_i;
    wire  [63:0] s_rw_addr_o;
    wire         s_rw_we_o;
    wire  [7:0]  s_rw_len_o;
    wire  [2:0]  s_rw_size_o;
    wire  [1:0]  s_rw_burst_o;
    wire         s_rw_if_o;
    wire         s_w_data_valid_o;
    logic        s_w_data_ready_i;
    wire  [63:0] s_w_data_o;
    logic        s_r_data_valid_i;
    wire         s_r_data_ready_o;
    logic [63:0] s_r_data_i;

    ysyx_22050133_mem_arbiter #(.RW_DATA_WIDTH(64), .RW_ADDR_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .m0_rw_addr_valid_i(m_av[0]), .m0_rw_addr_ready_o(m_ar[0]), .m0_rw_addr_i(m_addr[0]),
        .m0_rw_we_i(m_we[0]), .m0_rw_len_i(m_len[0]), .m0_rw_size_i(m_size[0]),
        .m0_rw_burst_i(m_burst[0]), .m0_rw_if_i(m_if[0]),
        .m0_w_data_valid_i(m_wv[0]), .m0_w_data_ready_o(m_wr[0]), .m0_w_data_i(m_wd[0]),
        .m0_r_data_valid_o(m_rv[0]), .m0_r_data_ready_i(m_rr[0]), .m0_r_data_o(m0_rd),
        .m1_rw_addr_valid_i(m_av[1]), .m1_rw_addr_ready_o(m_ar[1]), .m1_rw_addr_i(m_addr[1]),
        .m1_rw_we_i(m_we[1]), .m1_rw_len_i(m_len[1]), .m1_rw_size_i(m_size[1]),
        .m1_rw_burst_i(m_burst[1]), .m1_rw_if_i(m_if[1]),
        .m1_w_data_valid_i(m_wv[1]), .m1_w_data_ready_o(m_wr[1]), .m1_w_data_i(m_wd[1]),
        .m1_r_data_valid_o(m_rv[1]), .m1_r_data_ready_i(m_rr[1]), .m1_r_data_o(m1_rd),
        .s_rw_addr_valid_o(s_rw_addr_valid_o), .s_rw_addr_ready_i(s_rw_addr_ready_i),
        .s_rw_addr_o(s_rw_addr_o), .s_rw_we_o(s_rw_we_o), .s_rw_len_o(s_rw_len_o),
        .s_rw_size_o(s_rw_size_o), .s_rw_burst_o(s_rw_burst_o), .s_rw_if_o(s_rw_if_o),
        .s_w_data_valid_o(s_w_data_valid_o), .s_w_data_ready_i(s_w_data_ready_i),
        .s_w_data_o(s_w_data_o),
        .s_r_data_valid_i(s_r_data_valid_i), .s_r_data_ready_o(s_r_data_ready_o),
        .s_r_data_i(s_r_data_i)
    );

    int  n_checks = 0;
    int  n_errors = 0;
    tx_t exp_q[$];
    bit  model_last;
    bit  abort = 1'b0;
    bit  acc[2];
    int  rb[2];
    int  wb[2];
    bit  mon_busy = 1'b0;
    int  mon_beat = 0;

    // Stimulus knobs for the independent agents.
    bit a_mode, r_mode, wv_always, rr_always;
    int w_mode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int cyc);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no completion after %0d cycles, expected completion", name, cyc);
    endtask

    function automatic logic [63:0] wdata(input logic [63:0] a, input int b);
        return {a[31:0], a[63:32]} ^ (64'h0101_0101_0101_0101 * 64'(b + 1));
    endfunction

    function automatic logic [63:0] rdata(input logic [63:0] a, input int b);
        return ~a ^ (64'h1000_0000_0000_0001 * 64'(b + 3));
    endfunction

    function automatic tx_t rand_tx(input bit m);
        tx_t t;
        t.m     = m;
        t.addr  = {$urandom(), $urandom()} & ~64'h7;
        t.we    = 1'($urandom_range(0, 1));
        t.len   = 8'($urandom_range(0, 7));
        t.size  = 3'($urandom_range(0, 7));
        t.burst = 2'($urandom_range(0, 3));
        t.ifb   = 1'($urandom_range(0, 1));
        return t;
    endfunction

    // One master-side burst: address handshake, then all data beats.
    task automatic do_burst(input tx_t t);
        int m, beat, cyc;
        bit hs;
        m = int'(t.m);
        m_addr[m] = t.addr; m_we[m] = t.we; m_len[m] = t.len;
        m_size[m] = t.size; m_burst[m] = t.burst; m_if[m] = t.ifb;
        m_av[m] = 1'b1;
        hs = 1'b0;
        cyc = 0;
        while (!hs && !abort && cyc < MAXW) begin
            @(negedge clk);
            hs = m_ar[m];
            @(posedge clk); #1;
            cyc++;
        end
        m_av[m] = 1'b0;
        if (!hs) begin
            if (!abort) timeout("addr_handshake", cyc);
            return;
        end
        acc[m] = 1'b1;
        beat = 0;
        while (beat <= int'(t.len) && !abort && cyc < MAXW) begin
            if (t.we) begin
                m_wv[m] = wv_always ? 1'b1 : 1'($urandom_range(0, 1));
                m_wd[m] = wdata(t.addr, beat);
            end else begin
                m_rr[m] = rr_always ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            hs = t.we ? (m_wv[m] && m_wr[m]) : (m_rr[m] && m_rv[m]);
            @(posedge clk); #1;
            if (hs) beat++;
            cyc++;
        end
        m_wv[m] = 1'b0;
        m_rr[m] = 1'b0;
        if (beat <= int'(t.len) && !abort) timeout("data_beats", cyc);
    endtask

    task automatic run_single(input tx_t t);
        exp_q.push_back(t);
        model_last = t.m;
        do_burst(t);
    endtask

    // a is the m0 request, b the m1 request, raised in the same cycle.
    task automatic run_tie(input tx_t a, input tx_t b);
        bit winner;
        winner = !model_last;
        if (winner) begin
            exp_q.push_back(b); exp_q.push_back(a);
        end else begin
            exp_q.push_back(a); exp_q.push_back(b);
        end
        model_last = !winner;
        fork
            do_burst(a);
            do_burst(b);
        join
    endtask

    // Second requester arrives only after the first is already granted.
    task automatic run_overlap(input tx_t f, input tx_t s, input int gap);
        exp_q.push_back(f);
        exp_q.push_back(s);
        model_last = s.m;
        acc[f.m] = 1'b0;
        fork
            do_burst(f);
            begin
                for (int k = 0; k < MAXW && !acc[f.m] && !abort; k++) begin
                    @(posedge clk); #1;
                end
                repeat (gap) begin
                    @(posedge clk); #1;
                end
                do_burst(s);
            end
        join
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_last = 1'b1;
    endtask

    // Memory-side agent.
    initial begin : slave
        logic [63:0] s_addr, p_addr;
        logic [7:0]  s_len, p_len;
        int          s_beat;
        bit          in_rd, p_we, ahs, rhs, rst_s;
        s_rw_addr_ready_i = 1'b0; s_w_data_ready_i = 1'b0;
        s_r_data_valid_i = 1'b0; s_r_data_i = '0;
        s_addr = '0; s_len = '0; p_addr = '0; p_len = '0; p_we = 1'b0;
        s_beat = 0; in_rd = 1'b0;
        forever begin
            @(negedge clk);
            rst_s = rst;
            ahs = s_rw_addr_valid_o && s_rw_addr_ready_i;
            rhs = s_r_data_valid_i && s_r_data_ready_o;
            if (ahs) begin
                p_addr = s_rw_addr_o; p_len = s_rw_len_o; p_we = s_rw_we_o;
            end
            @(posedge clk); #1;
            if (rst_s) begin
                in_rd = 1'b0;
            end else if (ahs) begin
                s_addr = p_addr; s_len = p_len; in_rd = !p_we; s_beat = 0;
            end else if (rhs) begin
                if (s_beat == int'(s_len)) in_rd = 1'b0;
                s_beat++;
            end
            s_rw_addr_ready_i = a_mode ? 1'b1 : 1'($urandom_range(0, 1));
            case (w_mode)
                1:       s_w_data_ready_i = 1'b1;
                2:       s_w_data_ready_i = !s_w_data_ready_i;
                default: s_w_data_ready_i = 1'($urandom_range(0, 1));
            endcase
            s_r_data_valid_i = r_mode ? 1'b1 : 1'($urandom_range(0, 1));
            s_r_data_i = in_rd ? rdata(s_addr, s_beat) : {$urandom(), $urandom()};
        end
    end

    // Monitor: pops the expected burst on each slave address handshake.
    initial begin : monitor
        tx_t cur;
        bit  gap;
        gap = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_busy = 1'b0;
                mon_beat = 0;
                gap = 1'b0;
                continue;
            end
            if (gap) begin
                check("idle_gap", 64'(s_rw_addr_valid_o), 64'd0);
                gap = 1'b0;
            end
            if (!mon_busy) begin
                check("quiet_data", 64'({m_wr, m_rv, s_w_data_valid_o, s_r_data_ready_o}), 64'd0);
            end else if (cur.we) begin
                check("w_route", 64'({m_wr[cur.m], m_wr[!cur.m], s_w_data_valid_o}),
                      64'({s_w_data_ready_i, 1'b0, m_wv[cur.m]}));
                if (s_w_data_valid_o && s_w_data_ready_i) begin
                    check("w_data", s_w_data_o, wdata(cur.addr, mon_beat));
                    wb[cur.m]++;
                    mon_beat++;
                    if (mon_beat > int'(cur.len)) begin
                        mon_busy = 1'b0;
                        gap = 1'b1;
                    end
                end
            end else begin
                check("r_route", 64'({m_rv[cur.m], m_rv[!cur.m], s_r_data_ready_o}),
                      64'({s_r_data_valid_i, 1'b0, m_rr[cur.m]}));
                if (m_rv[cur.m] && m_rr[cur.m]) begin
                    check("r_data", cur.m ? m1_rd : m0_rd, rdata(cur.addr, mon_beat));
                    check("r_bcast", cur.m ? m0_rd : m1_rd, rdata(cur.addr, mon_beat));
                    rb[cur.m]++;
                    mon_beat++;
                    if (mon_beat > int'(cur.len)) begin
                        mon_busy = 1'b0;
                        gap = 1'b1;
                    end
                end
            end
            if (s_rw_addr_valid_o && s_rw_addr_ready_i) begin
                if (mon_busy || exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL addr_unexpected: got request addr %h, expected none (busy=%0d queued=%0d)",
                             s_rw_addr_o, mon_busy, exp_q.size());
                end else begin
                    cur = exp_q.pop_front();
                    check("a_route", 64'({m_ar[cur.m], m_ar[!cur.m]}), 64'b10);
                    check("a_addr", s_rw_addr_o, cur.addr);
                    check("a_ctrl", 64'({s_rw_we_o, s_rw_len_o, s_rw_size_o, s_rw_burst_o, s_rw_if_o}),
                          64'({cur.we, cur.len, cur.size, cur.burst, cur.ifb}));
                    mon_busy = 1'b1;
                    mon_beat = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        tx_t a, b;
        int  r0, r1, w1, k;
        m_av = '0; m_we = '0; m_if = '0; m_wv = '0; m_rr = '0;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_wd[i] = '0; m_len[i] = '0; m_size[i] = '0; m_burst[i] = '0;
            acc[i] = 1'b0; rb[i] = 0; wb[i] = 0;
        end
        a_mode = 1'b0; r_mode = 1'b0; wv_always = 1'b0; rr_always = 1'b0; w_mode = 0;
        model_last = 1'b1;

        do_reset();
        @(negedge clk);
        check("reset_quiet", 64'({m_ar, m_wr, m_rv, s_rw_addr_valid_o, s_w_data_valid_o, s_r_data_ready_o}), 64'd0);
        settle();

        // Two ties after reset: m0 first both times.
        a = rand_tx(1'b0); b = rand_tx(1'b1);
        run_tie(a, b);
        settle();
        a = rand_tx(1'b0); b = rand_tx(1'b1);
        run_tie(a, b);
        settle();

        // m1 read of 8 beats with an always-ready slave: one-cycle address latency.
        a_mode = 1'b1; r_mode = 1'b1; rr_always = 1'b1;
        a = rand_tx(1'b1); a.we = 1'b0; a.len = 8'd7;
        r0 = rb[0]; r1 = rb[1];
        exp_q.push_back(a);
        model_last = 1'b1;
        fork
            do_burst(a);
            begin
                @(negedge clk);
                check("lat_idle", 64'(s_rw_addr_valid_o), 64'd0);
                @(negedge clk);
                check("lat_addr", 64'(s_rw_addr_valid_o), 64'd1);
            end
        join
        check("m1_read_beats", 64'(rb[1] - r1), 64'd8);
        check("m0_read_beats", 64'(rb[0] - r0), 64'd0);
        settle();

        // m1 write of 4 beats with slave ready toggling.
        w_mode = 2; wv_always = 1'b1;
        a = rand_tx(1'b1); a.we = 1'b1; a.len = 8'd3;
        w1 = wb[1];
        run_single(a);
        check("m1_write_beats", 64'(wb[1] - w1), 64'd4);
        settle();

        // m0 asks during a long m1 read and must wait for its last beat.
        a_mode = 1'b0; r_mode = 1'b0; rr_always = 1'b0; w_mode = 0; wv_always = 1'b0;
        a = rand_tx(1'b1); a.we = 1'b0; a.len = 8'd7;
        b = rand_tx(1'b0);
        run_overlap(a, b, 2);
        settle();

        // Reset in the middle of an m0 write after two beats.
        a_mode = 1'b1; w_mode = 1; wv_always = 1'b1;
        a = rand_tx(1'b0); a.we = 1'b1; a.len = 8'd5;
        exp_q.push_back(a);
        model_last = 1'b0;
        fork
            do_burst(a);
            begin
                for (k = 0; k < MAXW && !(mon_busy && mon_beat >= 2); k++) begin
                    @(posedge clk); #1;
                end
                if (k >= MAXW) timeout("two_write_beats", k);
                rst = 1'b1;
                abort = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("midburst_reset_quiet",
                      64'({m_ar, m_wr, m_rv, s_rw_addr_valid_o, s_w_data_valid_o, s_r_data_ready_o}), 64'd0);
            end
        join
        abort = 1'b0;
        exp_q.delete();
        model_last = 1'b1;
        settle();
        a_mode = 1'b0; w_mode = 0; wv_always = 1'b0;
        a = rand_tx(1'b0);
        run_single(a);
        settle();

        // Randomized mix of single, tied and overlapping requests.
        for (int it = 0; it < 40; it++) begin
            a_mode    = 1'($urandom_range(0, 1));
            r_mode    = 1'($urandom_range(0, 1));
            wv_always = 1'($urandom_range(0, 1));
            rr_always = 1'($urandom_range(0, 1));
            w_mode    = int'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0: run_single(rand_tx(1'b0));
                1: run_single(rand_tx(1'b1));
                2: run_tie(rand_tx(1'b0), rand_tx(1'b1));
                default: begin
                    a = rand_tx(1'($urandom_range(0, 1)));
                    b = rand_tx(!a.m);
                    run_overlap(a, b, int'($urandom_range(0, 5)));
                end
            endcase
            settle();
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
